// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM capture scheduler.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        STORE   = 2'd3
    } sched_state_t;

    // Lowest set bit of mask at index >= from; returns {found, idx}.
    // Works on a 16-bit mask so it covers every legal channel count.
    function automatic logic [4:0] next_set_bit(input logic [15:0] mask, input logic [4:0] from);
        logic [4:0] res;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_sched_result_bank.sv
// Per-channel result storage for the capture scheduler: value, valid and
// timeout flags plus a combinational read port.
// Optional build macro PWM_CAP_SCHED_TOCNT_EN adds an 8-bit saturating
// timeout counter per channel; without it o_rd_tocnt reads 0.
module pwm_sched_result_bank #(
    parameter int K_DWIDTH = 16,
    parameter int K_NCH    = 4,
    parameter int K_CHW    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [K_CHW-1:0]    i_wr_ch,
    input  logic                i_wr_timeout,
    input  logic [K_DWIDTH-1:0] i_wr_value,
    input  logic [K_CHW-1:0]    i_rd_ch,
    output logic [K_DWIDTH-1:0] o_rd_value,
    output logic                o_rd_valid,
    output logic                o_rd_timeout,
    output logic [7:0]          o_rd_tocnt
);

    logic [K_DWIDTH-1:0] value_all [K_NCH];
    logic                valid_all [K_NCH];
    logic                tmo_all   [K_NCH];
`ifdef PWM_CAP_SCHED_TOCNT_EN
    logic [7:0]          tocnt_all [K_NCH];
`endif

    for (genvar gi = 0; gi < K_NCH; gi++) begin : g_ch
        logic                ch_wr;
        logic [K_DWIDTH-1:0] value_q;
        logic                valid_q;
        logic                tmo_q;

        assign ch_wr = i_wr_en && (i_wr_ch == K_CHW'(gi));

        // A timeout only raises the flag; a completed capture replaces the value.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                value_q <= '0;
                valid_q <= 1'b0;
                tmo_q   <= 1'b0;
            end else if (ch_wr) begin
                if (i_wr_timeout) begin
                    tmo_q <= 1'b1;
                end else begin
                    value_q <= i_wr_value;
                    valid_q <= 1'b1;
                    tmo_q   <= 1'b0;
                end
            end
        end

        assign value_all[gi] = value_q;
        assign valid_all[gi] = valid_q;
        assign tmo_all[gi]   = tmo_q;

`ifdef PWM_CAP_SCHED_TOCNT_EN
        logic [7:0] tocnt_q;

        // Saturating count of timeouts; only reset clears it.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                tocnt_q <= '0;
            end else if (ch_wr && i_wr_timeout && (tocnt_q != 8'hFF)) begin
                tocnt_q <= tocnt_q + 8'd1;
            end
        end

        assign tocnt_all[gi] = tocnt_q;
`endif
    end

    // Read mux; out-of-range addresses read as zero.
    always_comb begin
        o_rd_value   = '0;
        o_rd_valid   = 1'b0;
        o_rd_timeout = 1'b0;
        o_rd_tocnt   = '0;
        for (int i = 0; i < K_NCH; i++) begin
            if (i_rd_ch == K_CHW'(i)) begin
                o_rd_value   = value_all[i];
                o_rd_valid   = valid_all[i];
                o_rd_timeout = tmo_all[i];
`ifdef PWM_CAP_SCHED_TOCNT_EN
                o_rd_tocnt   = tocnt_all[i];
`endif
            end
        end
    end

endmodule

// File: rtl/pwm_capture_sched.sv
// Round-robin scheduler sharing one PWM capture engine among K_NCH inputs.
// A channel is armed only while its input sits at the inactive level so the
// engine never sees a partial pulse. Results land in pwm_sched_result_bank.
// Optional build macro PWM_CAP_SCHED_TOCNT_EN enables per-channel timeout counters.
module pwm_capture_sched
    import pwm_pkg::*;
#(
    parameter int  K_DWIDTH = 16,
    parameter int  K_NCH    = 4,
    localparam int K_CHW    = $clog2(K_NCH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_timebase,
    input  logic                i_enable,
    input  logic [K_NCH-1:0]    i_ch_mask,
    input  logic [K_NCH-1:0]    i_pwm,
    input  logic [K_NCH-1:0]    i_polarity,
    input  logic [K_DWIDTH-1:0] i_skip,
    input  logic [K_DWIDTH-1:0] i_timeout,
    output logic                o_cap_pwm,
    output logic                o_cap_polarity,
    output logic [K_DWIDTH-1:0] o_cap_skip,
    input  logic                i_cap_start,
    input  logic                i_cap_done,
    input  logic [K_DWIDTH-1:0] i_cap_value,
    input  logic [K_CHW-1:0]    i_rd_ch,
    output logic [K_DWIDTH-1:0] o_rd_value,
    output logic                o_rd_valid,
    output logic                o_rd_timeout,
    output logic [7:0]          o_rd_tocnt,
    output logic [K_CHW-1:0]    o_active_ch,
    output logic                o_busy,
    output logic                o_sweep_done
);

    sched_state_t        state_q, state_d;
    logic [K_CHW-1:0]    ch_q, ch_d;
    logic [K_NCH-1:0]    mask_q, mask_d;
    logic [K_DWIDTH-1:0] tcnt_q, tcnt_d;
    logic [K_DWIDTH-1:0] capv_q, capv_d;
    logic                to_q, to_d;
    logic                sweep_q, sweep_d;
    logic                wr_en;

    logic                pwm_sel, pol_sel, to_hit;
    logic [4:0]          nxt_in_mask, first_new;
    logic                unused_ok;

    assign pwm_sel     = i_pwm[ch_q];
    assign pol_sel     = i_polarity[ch_q];
    assign to_hit      = (i_timeout != '0) && (tcnt_q == i_timeout);
    assign nxt_in_mask = next_set_bit(16'(mask_q), 5'(ch_q) + 5'd1);
    assign first_new   = next_set_bit(16'(i_ch_mask), 5'd0);
    assign unused_ok   = i_cap_start ^ first_new[4];

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            mask_q  <= '0;
            tcnt_q  <= '0;
            capv_q  <= '0;
            to_q    <= 1'b0;
            sweep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            mask_q  <= mask_d;
            tcnt_q  <= tcnt_d;
            capv_q  <= capv_d;
            to_q    <= to_d;
            sweep_q <= sweep_d;
        end
    end

    // Next-state logic; dropping i_enable abandons whatever is in flight.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        mask_d  = mask_q;
        tcnt_d  = tcnt_q;
        capv_d  = capv_q;
        to_d    = to_q;
        sweep_d = 1'b0;
        wr_en   = 1'b0;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_ch_mask != '0) begin
                        mask_d  = i_ch_mask;
                        ch_d    = K_CHW'(first_new[3:0]);
                        tcnt_d  = '0;
                        state_d = ARM;
                    end
                end
                ARM: begin
                    tcnt_d = tcnt_q + K_DWIDTH'(i_timebase);
                    if (to_hit) begin
                        to_d    = 1'b1;
                        state_d = STORE;
                    end else if (pwm_sel == pol_sel) begin
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    tcnt_d = tcnt_q + K_DWIDTH'(i_timebase);
                    if (i_cap_done) begin
                        capv_d  = i_cap_value;
                        to_d    = 1'b0;
                        state_d = STORE;
                    end else if (to_hit) begin
                        to_d    = 1'b1;
                        state_d = STORE;
                    end
                end
                STORE: begin
                    wr_en  = 1'b1;
                    tcnt_d = '0;
                    if (nxt_in_mask[4]) begin
                        ch_d    = K_CHW'(nxt_in_mask[3:0]);
                        state_d = ARM;
                    end else begin
                        sweep_d = 1'b1;
                        mask_d  = i_ch_mask;
                        if (i_ch_mask != '0) begin
                            ch_d    = K_CHW'(first_new[3:0]);
                            state_d = ARM;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Engine routing: inactive level while arming, live input while measuring.
    always_comb begin
        o_cap_pwm      = 1'b0;
        o_cap_polarity = 1'b0;
        o_cap_skip     = '0;
        if (state_q != IDLE) begin
            o_cap_polarity = pol_sel;
            o_cap_skip     = i_skip;
            if (i_enable) begin
                o_cap_pwm = (state_q == MEASURE) ? pwm_sel : pol_sel;
            end
        end
    end

    assign o_active_ch  = ch_q;
    assign o_busy       = (state_q != IDLE);
    assign o_sweep_done = sweep_q;

    pwm_sched_result_bank #(
        .K_DWIDTH (K_DWIDTH),
        .K_NCH    (K_NCH),
        .K_CHW    (K_CHW)
    ) u_bank (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_wr_en      (wr_en),
        .i_wr_ch      (ch_q),
        .i_wr_timeout (to_q),
        .i_wr_value   (capv_q),
        .i_rd_ch      (i_rd_ch),
        .o_rd_value   (o_rd_value),
        .o_rd_valid   (o_rd_valid),
        .o_rd_timeout (o_rd_timeout),
        .o_rd_tocnt   (o_rd_tocnt)
    );

endmodule

// File: tb/tb_pwm_capture_sched.sv
// Directed testbench for pwm_capture_sched; the bench plays the capture engine.
module tb_pwm_capture_sched;

    logic        clk, rst_n, timebase, enable;
    logic [3:0]  ch_mask, pwm, polarity;
    logic [15:0] skip, timeout;
    logic        cap_pwm, cap_polarity;
    logic [15:0] cap_skip;
    logic        cap_start, cap_done;
    logic [15:0] cap_value;
    logic [1:0]  rd_ch;
    logic [15:0] rd_value;
    logic        rd_valid, rd_timeout;
    logic [7:0]  rd_tocnt;
    logic [1:0]  active_ch;
    logic        busy, sweep_done;

    int n_cmp = 0;
    int n_err = 0;

    pwm_capture_sched dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_timebase(timebase), .i_enable(enable),
        .i_ch_mask(ch_mask), .i_pwm(pwm), .i_polarity(polarity), .i_skip(skip),
        .i_timeout(timeout), .o_cap_pwm(cap_pwm), .o_cap_polarity(cap_polarity),
        .o_cap_skip(cap_skip), .i_cap_start(cap_start), .i_cap_done(cap_done),
        .i_cap_value(cap_value), .i_rd_ch(rd_ch), .o_rd_value(rd_value),
        .o_rd_valid(rd_valid), .o_rd_timeout(rd_timeout), .o_rd_tocnt(rd_tocnt),
        .o_active_ch(active_ch), .o_busy(busy), .o_sweep_done(sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [1:0] ch);
        rd_ch = ch;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; timebase = 1'b1; enable = 1'b0; ch_mask = '0; pwm = '0;
        polarity = '0; skip = '0; timeout = '0; cap_start = 1'b0; cap_done = 1'b0;
        cap_value = '0; rd_ch = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Entered with the DUT in ARM on ch and pwm[ch] low: measures one pulse
    // of width ticks, reports val as the engine result, and steps past STORE.
    task automatic meas(input int ch, input int width, input logic [15:0] val);
        tick();
        pwm[ch] = 1'b1;
        repeat (width) tick();
        pwm[ch] = 1'b0;
        cap_start = 1'b1; cap_done = 1'b1; cap_value = val;
        tick();
        cap_start = 1'b0; cap_done = 1'b0;
        tick();
        $display("meas ch%0d width %0d value %0d", ch, width, val);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; ch_mask = '0; pwm = '0; polarity = '0;
        skip = 16'h5; timeout = '0; timebase = 1'b1; cap_start = 1'b0;
        cap_done = 1'b0; cap_value = '0; rd_ch = '0;
        #2;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (cap_pwm !== 1'b0) begin n_err++; $display("FAIL reset_cap_pwm: got %0b want 0", cap_pwm); end
        n_cmp++; if (cap_skip !== 16'h0) begin n_err++; $display("FAIL reset_cap_skip: got %0h want 0", cap_skip); end
        n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL reset_sweep: got %0b want 0", sweep_done); end
        n_cmp++; if (active_ch !== 2'd0) begin n_err++; $display("FAIL reset_active: got %0d want 0", active_ch); end
        n_cmp++; if ({rd_valid, rd_timeout, rd_value, rd_tocnt} !== 26'h0) begin n_err++; $display("FAIL reset_rd: got %0h want 0", {rd_valid, rd_timeout, rd_value, rd_tocnt}); end
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_sweep();
        do_reset();
        skip = 16'd3; timeout = 16'd100; ch_mask = 4'b0101; enable = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sweep_busy: got %0b want 1", busy); end
        n_cmp++; if (active_ch !== 2'd0) begin n_err++; $display("FAIL sweep_first_ch: got %0d want 0", active_ch); end
        n_cmp++; if (cap_skip !== 16'd3) begin n_err++; $display("FAIL sweep_skip: got %0d want 3", cap_skip); end
        meas(0, 10, 16'd10);
        set_rd(2'd0);
        n_cmp++; if (active_ch !== 2'd2) begin n_err++; $display("FAIL sweep_next_ch: got %0d want 2", active_ch); end
        n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL sweep_mid_done: got %0b want 0", sweep_done); end
        n_cmp++; if ({rd_valid, rd_timeout, rd_value} !== {1'b1, 1'b0, 16'd10}) begin n_err++; $display("FAIL sweep_ch0: got v%0b t%0b %0d want v1 t0 10", rd_valid, rd_timeout, rd_value); end
        meas(2, 20, 16'd20);
        set_rd(2'd2);
        n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL sweep_end_done: got %0b want 1", sweep_done); end
        n_cmp++; if (active_ch !== 2'd0) begin n_err++; $display("FAIL sweep_restart_ch: got %0d want 0", active_ch); end
        n_cmp++; if ({rd_valid, rd_value} !== {1'b1, 16'd20}) begin n_err++; $display("FAIL sweep_ch2: got v%0b %0d want v1 20", rd_valid, rd_value); end
        set_rd(2'd1);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL sweep_ch1_valid: got %0b want 0", rd_valid); end
        set_rd(2'd3);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL sweep_ch3_valid: got %0b want 0", rd_valid); end
        tick();
        n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL sweep_pulse_len: got %0b want 0", sweep_done); end
    endtask

    task automatic test_arm_wait();
        do_reset();
        timeout = 16'd100; ch_mask = 4'b0010; pwm = 4'b0010; enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({active_ch, cap_pwm} !== {2'd1, 1'b0}) begin n_err++; $display("FAIL arm_hold_%0d: got ch%0d pwm%0b want ch1 pwm0", i, active_ch, cap_pwm); end
            tick();
        end
        pwm[1] = 1'b0;
        tick();
        pwm[1] = 1'b1;
        #1;
        n_cmp++; if (cap_pwm !== 1'b1) begin n_err++; $display("FAIL arm_measure_pwm: got %0b want 1", cap_pwm); end
        repeat (7) tick();
        pwm[1] = 1'b0; cap_done = 1'b1; cap_value = 16'd7;
        tick();
        cap_done = 1'b0;
        tick();
        set_rd(2'd1);
        n_cmp++; if ({rd_valid, rd_value} !== {1'b1, 16'd7}) begin n_err++; $display("FAIL arm_result: got v%0b %0d want v1 7", rd_valid, rd_value); end
        $display("arm wait ch1 value %0d", rd_value);
    endtask

    task automatic test_polarity();
        do_reset();
        ch_mask = 4'b0001; polarity = 4'b0001; pwm = 4'b0000; enable = 1'b1;
        tick();
        n_cmp++; if ({cap_polarity, cap_pwm} !== 2'b11) begin n_err++; $display("FAIL pol_arm: got pol%0b pwm%0b want 11", cap_polarity, cap_pwm); end
        tick();
        pwm[0] = 1'b1;
        tick();
        pwm[0] = 1'b0;
        #1;
        n_cmp++; if (cap_pwm !== 1'b0) begin n_err++; $display("FAIL pol_measure: got %0b want 0", cap_pwm); end
        $display("polarity check done");
    endtask

    task automatic test_timeout();
        do_reset();
        timeout = 16'd50; ch_mask = 4'b1000; enable = 1'b1;
        tick();
        meas(3, 10, 16'd33);
        n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL to_first_sweep: got %0b want 1", sweep_done); end
        repeat (51) tick();
        set_rd(2'd3);
        n_cmp++; if ({sweep_done, rd_timeout} !== 2'b00) begin n_err++; $display("FAIL to_early: got sweep%0b to%0b want 00", sweep_done, rd_timeout); end
        tick();
        n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL to_sweep: got %0b want 1", sweep_done); end
        n_cmp++; if ({rd_timeout, rd_valid, rd_value} !== {1'b1, 1'b1, 16'd33}) begin n_err++; $display("FAIL to_result: got t%0b v%0b %0d want t1 v1 33", rd_timeout, rd_valid, rd_value); end
        n_cmp++; if ({busy, active_ch} !== {1'b1, 2'd3}) begin n_err++; $display("FAIL to_rearm: got busy%0b ch%0d want busy1 ch3", busy, active_ch); end
`ifdef PWM_CAP_SCHED_TOCNT_EN
        n_cmp++; if (rd_tocnt !== 8'd1) begin n_err++; $display("FAIL to_cnt: got %0d want 1", rd_tocnt); end
`else
        n_cmp++; if (rd_tocnt !== 8'd0) begin n_err++; $display("FAIL to_cnt_off: got %0d want 0", rd_tocnt); end
`endif
        $display("timeout ch3 flagged");
        // Done and timeout on the same edge: done must win.
        timeout = 16'd5;
        tick();
        repeat (4) tick();
        cap_done = 1'b1; cap_value = 16'd77;
        tick();
        cap_done = 1'b0;
        tick();
        n_cmp++; if ({rd_timeout, rd_valid, rd_value} !== {1'b0, 1'b1, 16'd77}) begin n_err++; $display("FAIL to_tie: got t%0b v%0b %0d want t0 v1 77", rd_timeout, rd_valid, rd_value); end
        $display("done/timeout tie value %0d", rd_value);
`ifdef PWM_CAP_SCHED_TOCNT_EN
        timeout = 16'd2;
        repeat (300 * 4) tick();
        n_cmp++; if (rd_tocnt !== 8'd255) begin n_err++; $display("FAIL to_cnt_sat: got %0d want 255", rd_tocnt); end
        $display("timeout counter %0d", rd_tocnt);
`endif
    endtask

    task automatic test_disable();
        do_reset();
        timeout = 16'd0; ch_mask = 4'b0101; enable = 1'b1;
        tick();
        meas(0, 4, 16'd12);
        tick();
        pwm[2] = 1'b1;
        tick(); tick();
        n_cmp++; if (cap_pwm !== 1'b1) begin n_err++; $display("FAIL dis_measuring: got %0b want 1", cap_pwm); end
        enable = 1'b0;
        #1;
        n_cmp++; if (cap_pwm !== 1'b0) begin n_err++; $display("FAIL dis_cap_pwm: got %0b want 0", cap_pwm); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_busy: got %0b want 0", busy); end
        cap_done = 1'b1; cap_value = 16'd99;
        tick();
        cap_done = 1'b0; pwm[2] = 1'b0;
        tick();
        set_rd(2'd0);
        n_cmp++; if ({rd_valid, rd_value} !== {1'b1, 16'd12}) begin n_err++; $display("FAIL dis_kept: got v%0b %0d want v1 12", rd_valid, rd_value); end
        set_rd(2'd2);
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL dis_discard: got %0b want 0", rd_valid); end
        $display("disable mid-measure handled");
    endtask

    task automatic test_mask_change();
        do_reset();
        timeout = 16'd100; ch_mask = 4'b0011; enable = 1'b1;
        tick();
        meas(0, 3, 16'd5);
        n_cmp++; if (active_ch !== 2'd1) begin n_err++; $display("FAIL mc_ch1: got %0d want 1", active_ch); end
        ch_mask = 4'b1000;
        meas(1, 3, 16'd6);
        n_cmp++; if ({sweep_done, active_ch} !== {1'b1, 2'd3}) begin n_err++; $display("FAIL mc_switch: got sweep%0b ch%0d want sweep1 ch3", sweep_done, active_ch); end
        meas(3, 3, 16'd8);
        n_cmp++; if ({sweep_done, active_ch} !== {1'b1, 2'd3}) begin n_err++; $display("FAIL mc_single: got sweep%0b ch%0d want sweep1 ch3", sweep_done, active_ch); end
        set_rd(2'd1);
        n_cmp++; if (rd_value !== 16'd6) begin n_err++; $display("FAIL mc_ch1_val: got %0d want 6", rd_value); end
        set_rd(2'd3);
        n_cmp++; if (rd_value !== 16'd8) begin n_err++; $display("FAIL mc_ch3_val: got %0d want 8", rd_value); end
    endtask

    task automatic test_mask_zero();
        do_reset();
        ch_mask = 4'b0000; enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if ({busy, sweep_done} !== 2'b00) begin n_err++; $display("FAIL mz_cycle_%0d: got busy%0b sweep%0b want 00", i, busy, sweep_done); end
        end
        $display("mask zero idle");
    endtask

    task automatic test_async_reset();
        do_reset();
        timeout = 16'd100; ch_mask = 4'b0001; enable = 1'b1;
        tick();
        meas(0, 3, 16'd4);
        tick();
        pwm[0] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        set_rd(2'd0);
        n_cmp++; if ({busy, rd_valid, cap_pwm} !== 3'b000) begin n_err++; $display("FAIL async_rst: got busy%0b v%0b pwm%0b want 000", busy, rd_valid, cap_pwm); end
        pwm[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("async reset mid-measure");
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_arm_wait();
        test_polarity();
        test_timeout();
        test_disable();
        test_mask_change();
        test_mask_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_capture_sched.md
Name: pwm_capture_sched

Overview:
Round-robin scheduler that shares one PWM capture engine between K_NCH PWM inputs.
- Selects a channel and routes its PWM and configuration to the engine.
- Arms the engine only when the selected input is at its inactive level, so no partial pulse is measured.
- Collects the captured value or a timeout into per-channel result registers, readable through an addressed port.
- Sits between the pin synchronisers and the register bank of the PWM input subsystem.

Parameters:
K_DWIDTH, 16, width of capture values, skip and timeout.
K_NCH, 4, number of PWM channels (2..16).
K_CHW, $clog2(K_NCH), channel index width (derived, not overridden).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_timebase  in  1  counting pulse, same pulse fed to the engine
i_enable  in  1  scheduler run enable
i_ch_mask  in  K_NCH  per-channel enable, sampled at sweep start
i_pwm  in  K_NCH  synchronised PWM inputs
i_polarity  in  K_NCH  per-channel edge select, 0 = rising
i_skip  in  K_DWIDTH  skip count forwarded to the engine
i_timeout  in  K_DWIDTH  timebase ticks allowed per channel; 0 = no timeout
o_cap_pwm  out  1  PWM routed to the engine
o_cap_polarity  out  1  polarity routed to the engine
o_cap_skip  out  K_DWIDTH  skip routed to the engine
i_cap_start  in  1  engine capture-start pulse
i_cap_done  in  1  engine capture-done pulse
i_cap_value  in  K_DWIDTH  engine captured value
i_rd_ch  in  K_CHW  result read address
o_rd_value  out  K_DWIDTH  result of channel i_rd_ch
o_rd_valid  out  1  channel i_rd_ch holds a result
o_rd_timeout  out  1  last attempt on i_rd_ch timed out
o_rd_tocnt  out  8  timeout count of i_rd_ch (optional feature)
o_active_ch  out  K_CHW  channel currently selected
o_busy  out  1  state is not IDLE
o_sweep_done  out  1  one-clock pulse after the last masked channel is stored

Behaviour:
Reset values:
- All outputs 0.
- Result, valid and timeout arrays cleared.
- o_cap_pwm = 0, state IDLE.
- Read outputs are combinational from the arrays.

States: IDLE, ARM, MEASURE, STORE.

IDLE:
- If i_enable and i_ch_mask != 0: latch the mask, select the lowest set bit, clear the timeout counter, go to ARM.
- Mask all zeros: stay IDLE, o_busy = 0.

ARM:
- o_cap_pwm is forced to the inactive level (= i_polarity[ch]).
- Go to MEASURE on the first clock where i_pwm[ch] ^ i_polarity[ch] == 0.

MEASURE:
- o_cap_pwm = i_pwm[ch].
- On i_cap_done, capture i_cap_value and go to STORE.
- i_cap_start is informational only and does not change state.

Timeout:
- A counter increments on i_timebase in ARM and MEASURE.
- When it equals i_timeout (with i_timeout != 0): mark a timeout and go to STORE.
- If done and timeout occur in the same cycle, done wins.

STORE (1 clock):
- Done: value[ch] = captured value, valid[ch] = 1, timeout[ch] = 0.
- Timeout: timeout[ch] = 1; value and valid are unchanged.
- Then select the next set bit above ch in the latched mask, clear the counter and go to ARM.
- If no set bit remains: pulse o_sweep_done, relatch i_ch_mask, restart from its lowest bit if it is nonzero and i_enable is high, else go to IDLE.

Latency: a done pulse in MEASURE updates the result arrays two clocks later (MEASURE → STORE register, STORE write).

Other rules:
- i_enable deasserted in any state: go to IDLE next clock, discard the in-flight capture, keep stored results, o_cap_pwm = 0.
- Single-channel mask: the same channel is re-armed every sweep.
- o_cap_polarity and o_cap_skip are driven from the selected channel in every state except IDLE.
- An asynchronous reset mid-measurement clears everything.

Optional Feature:
PWM_CAP_SCHED_TOCNT_EN
- Defined: per-channel 8-bit saturating counter, incremented on each timeout STORE and never cleared except by reset, read via o_rd_tocnt.
- Undefined: counters are absent and o_rd_tocnt is tied to 0.

Decomposition:
- Package pwm_pkg holds the sched_state_t enum (IDLE, ARM, MEASURE, STORE) and the function next_set_bit(mask, from) returning {found, idx}.
- One sub-module: pwm_sched_result_bank (result/valid/timeout arrays, write port and read mux, plus the optional counters).

Test Plan:
- Mask 4'b0101, ch0 high 10 ticks, ch2 high 20 ticks, skip 0, timeout 100 → results ch0 ≈ 9–10 and ch2 ≈ 19–20 (engine ±1), valid ch0/ch2 only, o_sweep_done once per sweep.
- ch1 already high when selected (polarity 0) → remains in ARM until ch1 falls, o_cap_pwm = 0 throughout; the next full pulse is measured.
- ch3 held low, i_timeout = 50 → STORE after 50 ticks, o_rd_timeout = 1, valid unchanged, next channel armed; with the macro defined, tocnt increments per sweep and saturates at 255.
- Drop i_enable mid-MEASURE → IDLE next clock, o_busy = 0, previously stored results intact.
- Mask changed from 4'b0011 to 4'b1000 mid-sweep → current sweep finishes ch0/ch1, the next sweep measures ch3 only.
- Mask 0 with i_enable = 1 → stays IDLE, o_busy = 0, no o_sweep_done.
